// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-cycle two's-complement adder computing A + B + cin.
// Each clock adds one SLICE-bit lookahead slice, least significant slice first.
// The carry between slices is held only in carry_q.
// Optional feature macro: ADDER_ZN_FLAGS_EN
//   defined   -> ZF/NF are registered from the final sum together with VF/CF
//   undefined -> ZF/NF are tied low and no zero/negative detect logic exists
module nibble_serial_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             VF,
  output logic             CF,
  output logic             ZF,
  output logic             NF
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Elaboration-time sanity: the operand must split evenly into slices.
  if ((WIDTH % SLICE) != 0 || NSLICE < 1) begin : g_bad_params
    $error("nibble_serial_adder: WIDTH must be a non-zero multiple of SLICE");
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             vf_q, vf_d;
  logic             cf_q, cf_d;

  // Carry-lookahead carries for one slice: c[k] is the carry into bit k,
  // c[SLICE] the slice carry-out. Each carry is a flat sum of products.
  function automatic logic [SLICE:0] cla_carries(
    input logic [SLICE-1:0] g,
    input logic [SLICE-1:0] p,
    input logic             c0
  );
    logic [SLICE:0] c;
    logic           acc;
    logic           pp;
    c[0] = c0;
    for (int k = 0; k < SLICE; k++) begin
      acc = g[k];
      pp  = p[k];
      for (int j = k - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[k+1] = acc | (pp & c0);
    end
    return c;
  endfunction

  // Slice selection: split the latched operands into slices and pick one by index.
  logic [SLICE-1:0] a_sl [NSLICE];
  logic [SLICE-1:0] b_sl [NSLICE];
  logic [SLICE-1:0] op_a, op_b;
  logic [SLICE-1:0] slice_g, slice_p, slice_sum;
  logic [SLICE:0]   slice_c;
  logic [WIDTH-1:0] sum_upd;
  logic             last_slice;
  logic             accept;

  for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slices
    assign a_sl[gi] = a_q[gi*SLICE +: SLICE];
    assign b_sl[gi] = b_q[gi*SLICE +: SLICE];
    // Only the slice addressed by idx_q is rewritten; the rest hold.
    assign sum_upd[gi*SLICE +: SLICE] =
      (idx_q == IDX_W'(gi)) ? slice_sum : sum_q[gi*SLICE +: SLICE];
  end

  assign op_a      = a_sl[idx_q];
  assign op_b      = b_sl[idx_q];
  assign slice_g   = op_a & op_b;
  assign slice_p   = op_a ^ op_b;
  assign slice_c   = cla_carries(slice_g, slice_p, carry_q);
  assign slice_sum = slice_p ^ slice_c[SLICE-1:0];

  assign last_slice = (state_q == ST_ADD) && (idx_q == LAST_IDX);
  assign accept     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Next-state logic: accept, per-slice accumulation and flag capture.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    vf_d    = vf_q;
    cf_d    = cf_q;
    case (state_q)
      ST_ADD: begin
        sum_d   = sum_upd;
        carry_d = slice_c[SLICE];
        idx_d   = idx_q + IDX_W'(1);
        if (last_slice) begin
          cf_d    = slice_c[SLICE];
          vf_d    = slice_c[SLICE] ^ slice_c[SLICE-1];
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // A new request restarts from the IDLE or DONE cycle with no bubble.
    if (accept) begin
      a_d     = a;
      b_d     = b;
      carry_d = cin;
      sum_d   = '0;
      idx_d   = '0;
      state_d = ST_ADD;
    end
  end

  // State and datapath registers; reset wins over any pending start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      vf_q    <= 1'b0;
      cf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      vf_q    <= vf_d;
      cf_q    <= cf_d;
    end
  end

`ifdef ADDER_ZN_FLAGS_EN
  logic zf_q, nf_q;

  // Zero/negative flags taken from the completed sum on the last slice edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      zf_q <= 1'b0;
      nf_q <= 1'b0;
    end else if (last_slice) begin
      zf_q <= (sum_upd == '0);
      nf_q <= sum_upd[WIDTH-1];
    end
  end

  assign ZF = zf_q;
  assign NF = nf_q;
`else
  assign ZF = 1'b0;
  assign NF = 1'b0;
`endif

  assign busy = (state_q == ST_ADD);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign VF   = vf_q;
  assign CF   = cf_q;

endmodule
